// File: rtl/keycode_repeat_ctrl.sv
// Turns the keycode PIO level into press / auto-repeat / release events, timed in frame ticks,
// queued in a small FIFO for the game logic and configured over an Avalon-MM CSR slave.
module keycode_repeat_ctrl #(
    parameter logic [7:0] DELAY_DEF  = 8'd20,
    parameter logic [7:0] RATE_DEF   = 8'd4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  keycode,
    input  logic        frame_tick,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [8:0]  ev_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PEND, S_REPEAT} state_e;

    state_e          state_q, state_d;
    logic [7:0]      key_q, held_key_q, held_key_d, counter_q, counter_d;
    logic [7:0]      delay_q, delay_d, rate_q, rate_d;
    logic            enable_q, enable_d, repeat_en_q, repeat_en_d, overflow_q, overflow_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [8:0]      mem_q [FIFO_DEPTH];

    logic            csr_wr, push, pop, full, push_ok;
    logic [8:0]      push_data;
    logic            key_rel, key_chg, delay_hit, rate_hit;
    logic [7:0]      delay_eff, rate_eff, counter_inc;
    logic            unused_wdata;

    assign unused_wdata = ^writedata[31:8];
    assign csr_wr       = chipselect & ~write_n;

    // A programmed delay/rate of zero behaves like one tick.
    assign delay_eff   = (delay_q == 8'd0) ? 8'd1 : delay_q;
    assign rate_eff    = (rate_q == 8'd0) ? 8'd1 : rate_q;
    assign counter_inc = (counter_q == 8'hFF) ? 8'hFF : counter_q + 8'd1;
    assign delay_hit   = frame_tick && (({1'b0, counter_q} + 9'd1) >= {1'b0, delay_eff});
    assign rate_hit    = frame_tick && (({1'b0, counter_q} + 9'd1) >= {1'b0, rate_eff});
    assign key_rel     = (key_q == 8'd0);
    assign key_chg     = (key_q != 8'd0) && (key_q != held_key_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            key_q       <= 8'd0;
            held_key_q  <= 8'd0;
            counter_q   <= 8'd0;
            delay_q     <= DELAY_DEF;
            rate_q      <= RATE_DEF;
            enable_q    <= 1'b1;
            repeat_en_q <= 1'b1;
            overflow_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= keycode;
            held_key_q  <= held_key_d;
            counter_q   <= counter_d;
            delay_q     <= delay_d;
            rate_q      <= rate_d;
            enable_q    <= enable_d;
            repeat_en_q <= repeat_en_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_q) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (!key_rel) state_d = S_DELAY;
                S_DELAY: begin
                    if (key_rel)                       state_d = S_IDLE;
                    else if (key_chg)                  state_d = S_PEND;
                    else if (delay_hit && repeat_en_q) state_d = S_REPEAT;
                end
                S_PEND:   state_d = S_DELAY;
                S_REPEAT: begin
                    if (key_rel)      state_d = S_IDLE;
                    else if (key_chg) state_d = S_PEND;
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        push       = 1'b0;
        push_data  = 9'd0;
        held_key_d = held_key_q;
        counter_d  = counter_q;
        if (enable_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!key_rel) begin
                        push       = 1'b1;
                        push_data  = {1'b0, key_q};
                        held_key_d = key_q;
                        counter_d  = 8'd0;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (key_rel) begin
                        push      = 1'b1;
                        push_data = {1'b1, held_key_q};
                    end else if (key_chg) begin
                        // Release the old key now; its replacement is pressed from S_PEND.
                        push       = 1'b1;
                        push_data  = {1'b1, held_key_q};
                        held_key_d = key_q;
                        counter_d  = 8'd0;
                    end else if (frame_tick) begin
                        if (state_q == S_DELAY ? (delay_hit && repeat_en_q) : rate_hit) begin
                            push      = 1'b1;
                            push_data = {1'b0, held_key_q};
                            counter_d = 8'd0;
                        end else begin
                            counter_d = counter_inc;
                        end
                    end
                end
                S_PEND: begin
                    push      = 1'b1;
                    push_data = {1'b0, held_key_q};
                    if (frame_tick) counter_d = counter_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        delay_d     = delay_q;
        rate_d      = rate_q;
        enable_d    = enable_q;
        repeat_en_d = repeat_en_q;
        overflow_d  = overflow_q;
        if (csr_wr) begin
            unique case (address)
                2'd0: delay_d = writedata[7:0];
                2'd1: rate_d  = writedata[7:0];
                2'd2: begin
                    enable_d    = writedata[0];
                    repeat_en_d = writedata[1];
                end
                2'd3: overflow_d = 1'b0;
                default: ;
            endcase
        end
        // A drop in the same cycle as a clear still leaves the flag set.
        if (push && full && !pop) overflow_d = 1'b1;
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = (count_q != '0) && ev_ready;
    assign push_ok = push && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (!enable_q) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop);
        end
    end

    // NOTE: FIFO storage has no reset; contents are only visible while count_q is nonzero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign ev_valid = (count_q != '0);
    assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : 9'd0;

    always_comb begin
        readdata = 32'd0;
        unique case (address)
            2'd0: readdata[7:0] = delay_q;
            2'd1: readdata[7:0] = rate_q;
            2'd2: readdata[1:0] = {repeat_en_q, enable_q};
            2'd3: begin
                readdata[CW:1] = count_q;
                readdata[0]    = overflow_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_keycode_repeat_ctrl.sv
// Directed bench for keycode_repeat_ctrl: CSR reset values, press/repeat/release timing,
// key change, FIFO overflow, repeat disable, enable flush and asynchronous reset.
`timescale 1ns/1ps
module tb_keycode_repeat_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  keycode;
    logic        frame_tick;
    logic        ev_valid;
    logic        ev_ready;
    logic [8:0]  ev_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tick_num = 0;
    logic [8:0] ev_q[$];
    int         tick_q[$];
    int         cyc_q[$];

    always #5 clk = ~clk;

    keycode_repeat_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .keycode    (keycode),
        .frame_tick (frame_tick),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted event; inputs only change just after a rising edge.
    always @(negedge clk) begin
        if (reset_n && ev_valid && ev_ready) begin
            ev_q.push_back(ev_data);
            tick_q.push_back(tick_num);
            cyc_q.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        step(1);
        d = readdata;
    endtask

    task automatic tick(input int gap);
        tick_num   = tick_num + 1;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(gap);
    endtask

    task automatic clear_log();
        ev_q.delete();
        tick_q.delete();
        cyc_q.delete();
        tick_num = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'd20, 32'd4, 32'd3, 32'd0};
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; keycode = 8'd0; frame_tick = 1'b0; ev_ready = 1'b0;
        step(3);
        tests++;
        if (ev_valid !== 1'b0 || ev_data !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h, expected valid=0 data=000", ev_valid, ev_data);
        end
        reset_n = 1'b1;
        step(2);
        for (int i = 0; i < 4; i++) begin
            csr_read(2'(i), rd);
            tests++;
            if (rd !== exp_rd[i]) begin
                fails++;
                $display("FAIL reset_csr%0d: got %h, expected %h", i, rd, exp_rd[i]);
            end
        end
        csr_write(2'd1, 32'd7);
        csr_read(2'd1, rd);
        tests++;
        if (rd !== 32'd7) begin
            fails++;
            $display("FAIL rate_write: got %h, expected 00000007", rd);
        end
    endtask

    task automatic test_repeat();
        logic [8:0] exp_d [5];
        int         exp_t [5];
        exp_d = '{9'h01A, 9'h01A, 9'h01A, 9'h01A, 9'h11A};
        exp_t = '{0, 2, 5, 8, 10};
        ev_ready = 1'b1;
        csr_write(2'd0, 32'd2);
        csr_write(2'd1, 32'd3);
        clear_log();
        keycode = 8'h1A;
        step(4);
        for (int i = 0; i < 10; i++) tick(3);
        keycode = 8'h00;
        step(4);
        tests++;
        if (ev_q.size() != 5) begin
            fails++;
            $display("FAIL repeat_count: got %0d events, expected 5", ev_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= ev_q.size()) begin
                fails++;
                $display("FAIL repeat_ev%0d: got no event, expected %h at tick %0d", i, exp_d[i], exp_t[i]);
            end else if (ev_q[i] !== exp_d[i] || tick_q[i] != exp_t[i]) begin
                fails++;
                $display("FAIL repeat_ev%0d: got %h at tick %0d, expected %h at tick %0d",
                         i, ev_q[i], tick_q[i], exp_d[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_key_change();
        clear_log();
        keycode = 8'h04;
        step(4);
        keycode = 8'h07;
        step(5);
        tests++;
        if (ev_q.size() != 3) begin
            fails++;
            $display("FAIL change_count: got %0d events, expected 3", ev_q.size());
        end else if (ev_q[0] !== 9'h004 || ev_q[1] !== 9'h104 || ev_q[2] !== 9'h007) begin
            fails++;
            $display("FAIL change_seq: got %h %h %h, expected 004 104 007", ev_q[0], ev_q[1], ev_q[2]);
        end else if (cyc_q[2] != cyc_q[1] + 1) begin
            fails++;
            $display("FAIL change_adjacent: got gap %0d cycles, expected 1", cyc_q[2] - cyc_q[1]);
        end
        tick(3);
        tests++;
        if (ev_q.size() != 3) begin
            fails++;
            $display("FAIL change_early_repeat: got %0d events after 1 tick, expected 3", ev_q.size());
        end
        tick(3);
        tests++;
        if (ev_q.size() != 4 || ev_q[ev_q.size()-1] !== 9'h007) begin
            fails++;
            $display("FAIL change_first_repeat: got %0d events, last %h, expected 4 events, last 007",
                     ev_q.size(), ev_q.size() > 0 ? ev_q[ev_q.size()-1] : 9'h000);
        end
        keycode = 8'h00;
        step(4);
        tests++;
        if (ev_q.size() != 5 || ev_q[ev_q.size()-1] !== 9'h107) begin
            fails++;
            $display("FAIL change_release: got %0d events, last %h, expected 5 events, last 107",
                     ev_q.size(), ev_q.size() > 0 ? ev_q[ev_q.size()-1] : 9'h000);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [7:0]  keys [6];
        logic [8:0]  exp_d [4];
        keys  = '{8'h11, 8'h00, 8'h12, 8'h00, 8'h13, 8'h00};
        exp_d = '{9'h011, 9'h111, 9'h012, 9'h112};
        ev_ready = 1'b0;
        clear_log();
        keycode = keys[0];
        step(1);
        tests++;
        if (ev_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: got valid=%b one cycle after key edge, expected 0", ev_valid);
        end
        step(1);
        tests++;
        if (ev_valid !== 1'b1 || ev_data !== 9'h011) begin
            fails++;
            $display("FAIL latency_press: got valid=%b data=%h, expected valid=1 data=011", ev_valid, ev_data);
        end
        step(1);
        for (int i = 1; i < 6; i++) begin
            keycode = keys[i];
            step(3);
        end
        csr_read(2'd3, rd);
        tests++;
        if (rd !== 32'h9 || ev_data !== 9'h011) begin
            fails++;
            $display("FAIL overflow_status: got status=%h head=%h, expected status=00000009 head=011", rd, ev_data);
        end
        csr_write(2'd3, 32'd0);
        csr_read(2'd3, rd);
        tests++;
        if (rd !== 32'h8) begin
            fails++;
            $display("FAIL overflow_clear: got %h, expected 00000008", rd);
        end
        ev_ready = 1'b1;
        step(6);
        tests++;
        if (ev_q.size() != 4) begin
            fails++;
            $display("FAIL drain_count: got %0d events, expected 4", ev_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < ev_q.size()) begin
                tests++;
                if (ev_q[i] !== exp_d[i]) begin
                    fails++;
                    $display("FAIL drain_ev%0d: got %h, expected %h", i, ev_q[i], exp_d[i]);
                end
            end
        end
        csr_read(2'd3, rd);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL drain_status: got %h, expected 00000000", rd);
        end
    endtask

    task automatic test_no_repeat();
        csr_write(2'd2, 32'd1);
        clear_log();
        keycode = 8'h2C;
        step(4);
        for (int i = 0; i < 50; i++) tick(1);
        keycode = 8'h00;
        step(4);
        tests++;
        if (ev_q.size() != 2) begin
            fails++;
            $display("FAIL norepeat_count: got %0d events, expected 2", ev_q.size());
        end else if (ev_q[0] !== 9'h02C || ev_q[1] !== 9'h12C) begin
            fails++;
            $display("FAIL norepeat_seq: got %h %h, expected 02C 12C", ev_q[0], ev_q[1]);
        end
        csr_write(2'd2, 32'd3);
    endtask

    task automatic test_disable_and_reset();
        logic [31:0] rd;
        ev_ready = 1'b0;
        clear_log();
        keycode = 8'h33;
        step(4);
        tick(2);
        tick(2);
        csr_read(2'd3, rd);
        tests++;
        if (rd !== 32'h4) begin
            fails++;
            $display("FAIL disable_pre: got status %h, expected 00000004", rd);
        end
        csr_write(2'd2, 32'd0);
        step(2);
        csr_read(2'd3, rd);
        tests++;
        if (ev_valid !== 1'b0 || rd !== 32'h0) begin
            fails++;
            $display("FAIL disable_flush: got valid=%b status=%h, expected valid=0 status=00000000", ev_valid, rd);
        end
        csr_write(2'd2, 32'd3);
        step(1);
        tests++;
        if (ev_valid !== 1'b1 || ev_data !== 9'h033) begin
            fails++;
            $display("FAIL reenable_press: got valid=%b data=%h, expected valid=1 data=033", ev_valid, ev_data);
        end
        address = 2'd3;
        step(1);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (ev_valid !== 1'b0 || ev_data !== 9'd0 || readdata !== 32'd0) begin
            fails++;
            $display("FAIL async_reset: got valid=%b data=%h status=%h, expected valid=0 data=000 status=00000000",
                     ev_valid, ev_data, readdata);
        end
        keycode = 8'h00;
        csr_read(2'd0, rd);
        tests++;
        if (rd !== 32'd20) begin
            fails++;
            $display("FAIL reset_delay: got %h, expected 00000014", rd);
        end
        reset_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_repeat();
        test_key_change();
        test_overflow();
        test_no_repeat();
        test_disable_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keycode_repeat_ctrl.md
Name: keycode_repeat_ctrl

Overview:
Sequences the 8-bit keycode level published by the keycode PIO into discrete game-input events: press, auto-repeat and release. Press and repeat events are timed in frame ticks (VGA vsync pulses). Events are buffered in a 4-entry FIFO consumed by the game logic over a valid/ready handshake. Delay, rate and enable are configured by the NIOS II over an Avalon-MM slave with the same read/write timing as the PIO slaves.

Parameters:
DELAY_DEF, 8'd20, reset value of repeat_delay (frame ticks from press to first repeat)
RATE_DEF, 8'd4, reset value of repeat_rate (frame ticks between repeats)
FIFO_DEPTH, 4, event FIFO depth; power of 2 only; count width log2(DEPTH)+1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon CSR word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, combinational from address
keycode  in  8  level keycode from keycode PIO out_port; 0 = no key
frame_tick  in  1  single-cycle pulse per frame
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
ev_data  out  9  {is_release, keycode[7:0]}; 0 when empty

Behaviour:
- Reset (async, reset_n=0): state IDLE, held_key=0, tick counter=0, FIFO empty, ev_valid=0, ev_data=0, overflow=0, repeat_delay=DELAY_DEF, repeat_rate=RATE_DEF, enable=1, repeat_en=1. Reset mid-operation discards all queued events.
- CSR map (write when chipselect & ~write_n):
  - addr0 RW repeat_delay = writedata[7:0]
  - addr1 RW repeat_rate = writedata[7:0]
  - addr2 RW bit0 enable, bit1 repeat_en
  - addr3 RO bit0 overflow (sticky), bits[3:1] FIFO count; any write to addr3 clears overflow.
  - Unused read bits are 0. Effective delay/rate of 0 is treated as 1.
- keycode is registered once (key_q); all decisions use key_q, so an event enqueues 2 cycles after the keycode edge.
- FSM states:
  - IDLE: key_q!=0 -> enqueue {0,key_q}, held_key=key_q, counter=0, go DELAY.
  - DELAY: key_q==0 -> enqueue {1,held_key}, go IDLE. key_q!=held_key (nonzero) -> enqueue {1,held_key} then {0,key_q} on the next cycle, held_key=key_q, counter=0, stay DELAY. Otherwise count frame_ticks; on the tick where counter+1 == delay: if repeat_en, enqueue {0,held_key}, counter=0, go REPEAT; else stay DELAY with counter saturated.
  - REPEAT: release and key-change handling as in DELAY (a key change returns to DELAY). On the tick where counter+1 == rate, enqueue {0,held_key} and set counter=0.
- Key change emits 2 events on consecutive cycles through a 1-cycle PEND substate. frame_tick arriving during PEND is counted, not lost.
- enable=0: FSM forced to IDLE, FIFO flushed, no enqueue. Re-enable with a key held -> fresh press event.
- FIFO:
  - Push when full -> event dropped, overflow=1. Full with simultaneous pop -> push accepted.
  - Pop on ev_valid & ev_ready. ev_data is the registered head.
  - ev_valid=1 exactly when count!=0. Pop on empty is ignored.
- Writing repeat_rate/delay mid-hold takes effect on the next comparison; no counter reset. If counter >= new value, the next tick fires.

Test Plan:
- Reset, read addr0/1/2/3 -> 20, 4, 3, 0. Write addr1=7 -> read 7.
- ev_ready=1, delay=2, rate=3, keycode=0x1A held for 10 ticks then 0 -> ev_data 0x01A at ticks 0, 2, 5, 8, then 0x11A at release; exactly 5 events.
- Key 0x04 held, switches to 0x07 -> 0x104 then 0x007 on consecutive cycles; first repeat of 0x07 after a full delay.
- ev_ready=0, generate 6 events -> count=4, status reads 0x9. Write addr3 -> 0x8. Drain -> order preserved, first 4 events only.
- repeat_en=0, hold 0x2C for 50 ticks -> only press 0x02C, and 0x12C on release.
- Key held with 2 events queued, write addr2=0 -> count 0, ev_valid=0. Write addr2=3 -> immediate 0x0xx press; assert reset_n mid-DELAY -> all outputs return to reset values at once.
